// File: rtl/rv_x_regs_pkg.sv
// ============================================================================
// Module  : rv_x_regs_pkg
// Purpose : Shared types, constants and helpers for the multi-port x-register
//           file and its busy scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_x_regs_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t X0 = 5'd0;

    // Register width selected by the 64-bit option.
    function automatic int xlen_of(bit rv64);
        return rv64 ? 64 : 32;
    endfunction

    // Number of architectural registers (E variants expose only x0-x15).
    function automatic int nregs_of(bit rve);
        return rve ? 16 : 32;
    endfunction

    // True when the index names an implemented register (x0 included).
    function automatic logic is_valid_reg(reg_idx_t idx, bit rve);
        return !rve || !idx[4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_x_regs_scoreboard.sv
// ============================================================================
// Module  : rv_x_regs_scoreboard
// Purpose : Per-register busy flags. Decode reserves a destination register,
//           writeback clears it. A write and a reservation to the same register
//           in one cycle leave it busy (the reservation is the younger one).
// Ports   : clock, reset       - clock, async active-high reset
//           wr_en/wr_addr      - writeback ports (clear busy)
//           rsv_en/rsv_addr    - reservation request, rsv_ok = accepted
//           busy_o             - registered busy flags
//           clr_o              - registers being written this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_x_regs_scoreboard
    import rv_x_regs_pkg::*;
#(
    parameter bit RVE       = 1'b0,
    parameter int NUM_WRITE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_WRITE-1:0]     wr_en,
    input  reg_idx_t [NUM_WRITE-1:0] wr_addr,
    input  logic                     rsv_en,
    input  reg_idx_t                 rsv_addr,
    output logic                     rsv_ok,
    output logic [31:0]              busy_o,
    output logic [31:0]              clr_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [31:0] clr_vec;
    logic [31:0] set_vec;

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (wr_en[i] && (wr_addr[i] != X0) && is_valid_reg(wr_addr[i], RVE)) begin
                clr_vec[wr_addr[i]] = 1'b1;
            end
        end
    end

    // x0 is never marked busy, so a reservation of x0 is always accepted.
    // A busy register may be re-reserved only when it is retired this cycle.
    assign rsv_ok = rsv_en && is_valid_reg(rsv_addr, RVE)
                    && (!busy_q[rsv_addr] || clr_vec[rsv_addr]);

    always_comb begin
        set_vec = '0;
        if (rsv_ok && (rsv_addr != X0)) begin
            set_vec[rsv_addr] = 1'b1;
        end
    end

    // Set after clear: a simultaneous reserve and write ends busy.
    assign busy_d = (busy_q & ~clr_vec) | set_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign clr_o  = clr_vec;

endmodule

`default_nettype wire

// File: rtl/rv_x_regs_mp.sv
// ============================================================================
// Module  : rv_x_regs_mp
// Purpose : Multi-port integer register file with same-cycle write bypass and
//           an integrated busy scoreboard.
// Ports   : clock, reset       - clock, async active-high reset
//           wr_en/addr/data    - NUM_WRITE write ports (highest index wins)
//           rd_addr            - NUM_READ read addresses
//           rd_data/rd_busy    - combinational read data and busy flag
//           rsv_en/rsv_addr    - reservation request from decode
//           rsv_ok             - reservation accepted this cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_x_regs_mp
    import rv_x_regs_pkg::*;
#(
    parameter bit RV64      = 1'b1,
    parameter bit RVE       = 1'b0,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_WRITE-1:0]                      wr_en,
    input  reg_idx_t [NUM_WRITE-1:0]                  wr_addr,
    input  logic [NUM_WRITE-1:0][xlen_of(RV64)-1:0]   wr_data,
    input  reg_idx_t [NUM_READ-1:0]                   rd_addr,
    output logic [NUM_READ-1:0][xlen_of(RV64)-1:0]    rd_data,
    output logic [NUM_READ-1:0]                       rd_busy,
    input  logic                                      rsv_en,
    input  reg_idx_t                                  rsv_addr,
    output logic                                      rsv_ok
);

    localparam int XLEN  = xlen_of(RV64);
    localparam int NREGS = nregs_of(RVE);
    localparam int AW    = $clog2(NREGS);

    logic [XLEN-1:0]      regs_q [NREGS];
    logic [XLEN-1:0]      regs_d [NREGS];
    logic [NUM_WRITE-1:0] wr_vld;
    logic [31:0]          busy_vec;
    logic [31:0]          clr_vec;

    always_comb begin
        for (int i = 0; i < NUM_WRITE; i++) begin
            wr_vld[i] = wr_en[i] && (wr_addr[i] != X0) && is_valid_reg(wr_addr[i], RVE);
        end
    end

    // Ascending port order: the highest-index port overrides lower ones.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (wr_vld[i]) begin
                regs_d[wr_addr[i][AW-1:0]] = wr_data[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    rv_x_regs_scoreboard #(
        .RVE       (RVE),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy_o   (busy_vec),
        .clr_o    (clr_vec)
    );

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
            logic [XLEN-1:0] data_w;
            logic            busy_w;

            always_comb begin
                data_w = '0;
                busy_w = 1'b0;
                if ((rd_addr[p] != X0) && is_valid_reg(rd_addr[p], RVE)) begin
                    data_w = regs_q[rd_addr[p][AW-1:0]];
                    busy_w = busy_vec[rd_addr[p]];
                    if (BYPASS) begin
                        for (int i = 0; i < NUM_WRITE; i++) begin
                            if (wr_vld[i] && (wr_addr[i] == rd_addr[p])) begin
                                data_w = wr_data[i];
                            end
                        end
                        // The forwarded write retires the producer, so the
                        // register is no longer pending for this reader.
                        if (clr_vec[rd_addr[p]]) begin
                            busy_w = 1'b0;
                        end
                    end
                end
            end

            assign rd_data[p] = data_w;
            assign rd_busy[p] = busy_w;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rv_x_regs_mp.sv
// ============================================================================
// Module  : tb_rv_x_regs_mp
// Purpose : Self-checking bench for rv_x_regs_mp. Two instances share stimulus:
//           A = RV64, 32 regs, 2 write ports, bypass on
//           B = RV32, E variant (16 regs), 2 write ports, bypass off
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_x_regs_mp;

    logic             clock;
    logic             reset;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][63:0] wr_data;
    logic [1:0][31:0] wr_data32;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][63:0] rd_a;
    logic [1:0][31:0] rd_b;
    logic [1:0]       busy_a;
    logic [1:0]       busy_b;
    logic             rsv_en;
    logic [4:0]       rsv_addr;
    logic             ok_a;
    logic             ok_b;

    assign wr_data32[0] = wr_data[0][31:0];
    assign wr_data32[1] = wr_data[1][31:0];

    rv_x_regs_mp #(.RV64(1'b1), .RVE(1'b0), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1'b1)) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_a), .rd_busy(busy_a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_a)
    );

    rv_x_regs_mp #(.RV64(1'b0), .RVE(1'b1), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1'b0)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data32),
        .rd_addr(rd_addr), .rd_data(rd_b), .rd_busy(busy_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_err;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (k=0 -> A, k=1 -> B) ----------------
    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];
    bit          cfg_rve [2];
    bit          cfg_byp [2];

    function automatic logic [63:0] mask_of(int k);
        return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit exists(int k, int a);
        return !cfg_rve[k] || (a < 16);
    endfunction

    function automatic bit writable(int k, int a);
        return (a != 0) && exists(k, a);
    endfunction

    // Value written to register a this cycle, if any (last port wins).
    function automatic bit written(int k, int a, output logic [63:0] d);
        bit hit;
        hit = 0;
        d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i] && writable(k, int'(wr_addr[i])) && (int'(wr_addr[i]) == a)) begin
                hit = 1;
                d   = wr_data[i] & mask_of(k);
            end
        end
        return hit;
    endfunction

    function automatic bit model_ok(int k);
        logic [63:0] d;
        int a;
        a = int'(rsv_addr);
        if (!rsv_en || !exists(k, a)) return 0;
        if (a == 0) return 1;
        return !m_busy[k][a] || written(k, a, d);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = '0;
                m_busy[k][r] = 0;
            end
        end
    endtask

    // Call just after a rising edge, while the inputs of that cycle are stable.
    task automatic model_update();
        bit ok;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            ok = model_ok(k);
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && writable(k, int'(wr_addr[i]))) begin
                    m_regs[k][wr_addr[i]] = wr_data[i] & mask_of(k);
                    m_busy[k][wr_addr[i]] = 0;
                end
            end
            if (ok && (rsv_addr != 5'd0)) m_busy[k][rsv_addr] = 1;
        end
    endtask

    task automatic model_check(int cyc);
        logic [63:0] ed;
        logic [63:0] fd;
        logic [63:0] act;
        bit          eb;
        int          a;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                a  = int'(rd_addr[p]);
                ed = '0;
                eb = 0;
                if (writable(k, a)) begin
                    ed = m_regs[k][a];
                    eb = m_busy[k][a];
                    if (cfg_byp[k] && written(k, a, fd)) begin
                        ed = fd;
                        eb = 0;
                    end
                end
                act = (k == 0) ? rd_a[p] : {32'd0, rd_b[p]};
                chk($sformatf("rnd c%0d k%0d rd_data%0d", cyc, k, p), act, ed);
                chk($sformatf("rnd c%0d k%0d rd_busy%0d", cyc, k, p),
                    {63'd0, (k == 0) ? busy_a[p] : busy_b[p]}, {63'd0, eb});
            end
            chk($sformatf("rnd c%0d k%0d rsv_ok", cyc, k),
                {63'd0, (k == 0) ? ok_a : ok_b}, {63'd0, model_ok(k)});
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        rs;
        logic [4:0]  rsa;
        logic [63:0] ad0;
        logic [63:0] ad1;
        logic        ab0;
        logic        aok;
        logic [63:0] bd0;
        logic [63:0] bd1;
        logic        bb0;
        logic        bok;
    } vec_t;

    localparam logic [63:0] DB  = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] BIG = 64'hA5A5_0000_0000_0005;

    vec_t tbl [17];
    int   pool [8];

    initial begin
        n_chk = 0;
        n_err = 0;
        cfg_rve[0] = 0; cfg_byp[0] = 1;
        cfg_rve[1] = 1; cfg_byp[1] = 0;
        pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 9;
        pool[4] = 15; pool[5] = 16; pool[6] = 20; pool[7] = 31;

        //            we    wa0    wd0       wa1    wd1    ra0    ra1    rs  rsa      A:d0   d1    b0 ok   B:d0  d1   b0 ok
        tbl[0]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd5,  5'd0,  0, 5'd0,   64'd0, 64'd0, 0, 0,  64'd0, 64'd0, 0, 0};
        tbl[1]  = '{2'b01, 5'd5,  DB,       5'd0,  64'd0, 5'd5,  5'd5,  0, 5'd0,   DB,    DB,    0, 0,  64'd0, 64'd0, 0, 0};
        tbl[2]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd5,  5'd7,  0, 5'd0,   DB,    64'd0, 0, 0,  DB,    64'd0, 0, 0};
        tbl[3]  = '{2'b11, 5'd7,  64'h11,   5'd7,  64'h22, 5'd7, 5'd5,  0, 5'd0,   64'h22, DB,   0, 0,  64'd0, DB,    0, 0};
        tbl[4]  = '{2'b01, 5'd0,  64'hFF,   5'd0,  64'd0, 5'd7,  5'd0,  0, 5'd0,   64'h22, 64'd0, 0, 0, 64'h22, 64'd0, 0, 0};
        tbl[5]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd9,  5'd7,  1, 5'd9,   64'd0, 64'h22, 0, 1, 64'd0, 64'h22, 0, 1};
        tbl[6]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd9,  5'd0,  1, 5'd9,   64'd0, 64'd0, 1, 0,  64'd0, 64'd0, 1, 0};
        tbl[7]  = '{2'b01, 5'd9,  64'h3,    5'd0,  64'd0, 5'd9,  5'd9,  0, 5'd0,   64'h3, 64'h3, 0, 0,  64'd0, 64'd0, 1, 0};
        tbl[8]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd9,  5'd7,  0, 5'd0,   64'h3, 64'h22, 0, 0, 64'h3, 64'h22, 0, 0};
        tbl[9]  = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd9,  5'd0,  1, 5'd9,   64'h3, 64'd0, 0, 1,  64'h3, 64'd0, 0, 1};
        tbl[10] = '{2'b01, 5'd9,  64'h44,   5'd0,  64'd0, 5'd9,  5'd9,  1, 5'd9,   64'h44, 64'h44, 0, 1, 64'h3, 64'h3, 1, 1};
        tbl[11] = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd9,  5'd5,  0, 5'd0,   64'h44, DB,   1, 0,  64'h44, DB,   1, 0};
        tbl[12] = '{2'b01, 5'd20, 64'h5,    5'd0,  64'd0, 5'd20, 5'd20, 1, 5'd20,  64'h5, 64'h5, 0, 1,  64'd0, 64'd0, 0, 0};
        tbl[13] = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd20, 5'd0,  0, 5'd0,   64'h5, 64'd0, 1, 0,  64'd0, 64'd0, 0, 0};
        tbl[14] = '{2'b01, 5'd15, BIG,      5'd0,  64'd0, 5'd15, 5'd0,  0, 5'd0,   BIG,   64'd0, 0, 0,  64'd0, 64'd0, 0, 0};
        tbl[15] = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd15, 5'd20, 0, 5'd0,   BIG,   64'h5, 0, 0,  64'h5, 64'd0, 0, 0};
        tbl[16] = '{2'b00, 5'd0,  64'd0,    5'd0,  64'd0, 5'd0,  5'd9,  1, 5'd0,   64'd0, 64'h44, 0, 1, 64'd0, 64'h44, 0, 1};

        reset    = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < 17; i++) begin
            wr_en      = tbl[i].we;
            wr_addr[0] = tbl[i].wa0;
            wr_data[0] = tbl[i].wd0;
            wr_addr[1] = tbl[i].wa1;
            wr_data[1] = tbl[i].wd1;
            rd_addr[0] = tbl[i].ra0;
            rd_addr[1] = tbl[i].ra1;
            rsv_en     = tbl[i].rs;
            rsv_addr   = tbl[i].rsa;
            #1;
            chk($sformatf("row%0d A rd_data0", i), rd_a[0], tbl[i].ad0);
            chk($sformatf("row%0d A rd_data1", i), rd_a[1], tbl[i].ad1);
            chk($sformatf("row%0d A rd_busy0", i), {63'd0, busy_a[0]}, {63'd0, tbl[i].ab0});
            chk($sformatf("row%0d A rsv_ok", i),   {63'd0, ok_a}, {63'd0, tbl[i].aok});
            chk($sformatf("row%0d B rd_data0", i), {32'd0, rd_b[0]}, tbl[i].bd0);
            chk($sformatf("row%0d B rd_data1", i), {32'd0, rd_b[1]}, tbl[i].bd1);
            chk($sformatf("row%0d B rd_busy0", i), {63'd0, busy_b[0]}, {63'd0, tbl[i].bb0});
            chk($sformatf("row%0d B rsv_ok", i),   {63'd0, ok_b}, {63'd0, tbl[i].bok});
            @(posedge clock);
            model_update();
            @(negedge clock);
        end

        // ---- asynchronous reset mid-cycle, with writes pending ----
        // x9 is busy in both instances and x5 holds DEADBEEF at this point.
        wr_en      = 2'b11;
        wr_addr[0] = 5'd3;
        wr_data[0] = 64'h77;
        wr_addr[1] = 5'd4;
        wr_data[1] = 64'h88;
        rd_addr[0] = 5'd9;
        rd_addr[1] = 5'd5;
        rsv_en     = 1'b1;
        rsv_addr   = 5'd6;
        reset      = 1'b1;
        #1;
        chk("async_rst A rd_data1", rd_a[1], 64'd0);
        chk("async_rst A rd_busy0", {63'd0, busy_a[0]}, 64'd0);
        chk("async_rst B rd_data1", {32'd0, rd_b[1]}, 64'd0);
        chk("async_rst B rd_busy0", {63'd0, busy_b[0]}, 64'd0);
        @(posedge clock);
        model_update();
        @(negedge clock);
        reset      = 1'b0;
        wr_en      = '0;
        rsv_en     = 1'b0;
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd4;
        #1;
        chk("rst_discard A x3", rd_a[0], 64'd0);
        chk("rst_discard A x4", rd_a[1], 64'd0);
        chk("rst_discard B x3", {32'd0, rd_b[0]}, 64'd0);
        chk("rst_discard B x4", {32'd0, rd_b[1]}, 64'd0);
        rd_addr[0] = 5'd6;
        #1;
        chk("rst_discard A busy x6", {63'd0, busy_a[0]}, 64'd0);
        @(posedge clock);
        model_update();
        @(negedge clock);

        // ---- randomized phase against the reference model ----
        for (int c = 0; c < 400; c++) begin
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr[0] = 5'(pool[$urandom_range(0, 7)]);
            wr_addr[1] = 5'(pool[$urandom_range(0, 7)]);
            wr_data[0] = {32'($urandom), 32'($urandom)};
            wr_data[1] = {32'($urandom), 32'($urandom)};
            rd_addr[0] = 5'(pool[$urandom_range(0, 7)]);
            rd_addr[1] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'(pool[$urandom_range(0, 7)]);
            rsv_en     = 1'($urandom_range(0, 1));
            rsv_addr   = 5'(pool[$urandom_range(0, 7)]);
            #1;
            model_check(c);
            @(posedge clock);
            model_update();
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
